// File: rtl/sr_cmd_pkg.sv
// Shared types and constants for the SR command controller.
package sr_cmd_pkg;

    localparam int CNT_W               = 4;
    localparam int DB_CYCLES_DEF       = 4;
    localparam int HOLDOFF_CYCLES_DEF  = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE_SET = 2'd1,
        ISSUE_CLR = 2'd2,
        HOLDOFF   = 2'd3
    } state_t;

endpackage

// File: rtl/sr_debounce.sv
// Saturating debounce counter with a registered debounced level for one raw input.
module sr_debounce
    import sr_cmd_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level
);

    localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DB_CYCLES);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // NOTE: assign a default first so every path drives cnt_next and no latch is inferred.
    always_comb begin
        cnt_next = cnt;
        if (!din)
            cnt_next = '0;
        else if (cnt != DB_MAX)
            cnt_next = cnt + 1'b1;
    end

    // Level tracks the next count so it rises on the same edge the count saturates.
    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            cnt   <= cnt_next;
            level <= (cnt_next == DB_MAX);
        end
    end

endmodule

// File: rtl/sr_cmd_ctrl.sv
// Debounced set/clear command issuer for a downstream SR flip-flop.
// Optional SR_CMD_SYNC_EN adds two-flop input synchronizers ahead of the debouncers.
module sr_cmd_ctrl
    import sr_cmd_pkg::*;
#(
    parameter int DB_CYCLES      = DB_CYCLES_DEF,
    parameter int HOLDOFF_CYCLES = HOLDOFF_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic set_in,
    input  logic clr_in,
    output logic s,
    output logic r,
    output logic busy,
    output logic conflict
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);

    logic set_src;
    logic clr_src;

`ifdef SR_CMD_SYNC_EN
    logic [1:0] set_sync;
    logic [1:0] clr_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            set_sync <= 2'b00;
            clr_sync <= 2'b00;
        end else begin
            set_sync <= {set_sync[0], set_in};
            clr_sync <= {clr_sync[0], clr_in};
        end
    end

    assign set_src = set_sync[1];
    assign clr_src = clr_sync[1];
`else
    assign set_src = set_in;
    assign clr_src = clr_in;
`endif

    logic set_lvl;
    logic clr_lvl;

    sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_set (
        .clk   (clk),
        .rst   (rst),
        .din   (set_src),
        .level (set_lvl)
    );

    sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
        .clk   (clk),
        .rst   (rst),
        .din   (clr_src),
        .level (clr_lvl)
    );

    logic set_lvl_q;
    logic clr_lvl_q;
    logic set_rise;
    logic clr_rise;
    logic set_pend;
    logic clr_pend;

    assign set_rise = set_lvl & ~set_lvl_q;
    assign clr_rise = clr_lvl & ~clr_lvl_q;

    state_t           state;
    logic [CNT_W-1:0] hold_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            set_lvl_q <= 1'b0;
            clr_lvl_q <= 1'b0;
            set_pend  <= 1'b0;
            clr_pend  <= 1'b0;
            state     <= IDLE;
            hold_cnt  <= '0;
            s         <= 1'b0;
            r         <= 1'b0;
            busy      <= 1'b0;
            conflict  <= 1'b0;
        end else begin
            set_lvl_q <= set_lvl;
            clr_lvl_q <= clr_lvl;
            // Requests keep accumulating in every state; IDLE overrides when it consumes one.
            set_pend  <= set_pend | set_rise;
            clr_pend  <= clr_pend | clr_rise;
            s         <= 1'b0;
            r         <= 1'b0;
            conflict  <= 1'b0;

            case (state)
                IDLE: begin
                    if (set_pend && clr_pend) begin
                        state    <= HOLDOFF;
                        hold_cnt <= HOLD_LOAD;
                        conflict <= 1'b1;
                        busy     <= 1'b1;
                        set_pend <= set_rise;
                        clr_pend <= clr_rise;
                    end else if (set_pend) begin
                        state    <= ISSUE_SET;
                        s        <= 1'b1;
                        busy     <= 1'b1;
                        set_pend <= set_rise;
                    end else if (clr_pend) begin
                        state    <= ISSUE_CLR;
                        r        <= 1'b1;
                        busy     <= 1'b1;
                        clr_pend <= clr_rise;
                    end else begin
                        busy     <= 1'b0;
                    end
                end
                ISSUE_SET, ISSUE_CLR: begin
                    state    <= HOLDOFF;
                    hold_cnt <= HOLD_LOAD;
                    busy     <= 1'b1;
                end
                HOLDOFF: begin
                    if (hold_cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                        busy     <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
